hw1_sweep_ctrl: RTL and testbench

//  Sequencer that exhaustively sweeps the 4-input combinational hw1 block in hardware.
//  It drives every input combination {A,B,C,D} = 0..15 and waits a programmable settle time.
//  It then samples hw1.out into a truth-table register and checks it against an expected table.

---
 rtl/hw1_sweep_ctrl_pkg.sv | 11 +
 rtl/hw1_sweep_ctrl.sv | 126 ++++++++++++
 tb/tb_hw1_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hw1_sweep_ctrl_pkg.sv
// rtl/hw1_sweep_ctrl_pkg.sv - shared state encoding for the hw1 sweep sequencer
package hw1_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/hw1_sweep_ctrl.sv
// rtl/hw1_sweep_ctrl.sv - exhaustive input sweep and truth-table self-check for hw1
module hw1_sweep_ctrl
  import hw1_sweep_ctrl_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        err_cnt,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail,
  output logic                 pass
);

  localparam int NV = 2**N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  sweep_state_e        state_q;
  logic [N_IN-1:0]     idx_q;
  logic [SW-1:0]       scnt_q;
  logic [N_IN-1:0]     vec_q;
  logic                busy_q;
  logic                done_q;
  logic [NV-1:0]       tt_q;
  logic [N_IN:0]       err_q;
  logic                fv_q;
  logic [N_IN-1:0]     ff_q;
  logic                pass_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      scnt_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_SETTLE;
            idx_q   <= '0;
            scnt_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            tt_q    <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else if (scnt_q == SW'(SETTLE - 1)) begin
            state_q <= S_SAMPLE;
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
        end
        S_SAMPLE: begin
          // An abort here discards the sample for the current vector.
          if (abort) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            tt_q[idx_q] <= f_in;
            if (f_in != expected[idx_q]) begin
              err_q <= err_q + (N_IN+1)'(1);
              if (!fv_q) begin
                fv_q <= 1'b1;
                ff_q <= idx_q;
              end
            end
            if (idx_q == N_IN'(NV - 1)) begin
              state_q <= S_DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_SETTLE;
              idx_q   <= idx_q + N_IN'(1);
              vec_q   <= idx_q + N_IN'(1);
              scnt_q  <= '0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec         = vec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign err_cnt     = err_q;
  assign fail_valid  = fv_q;
  assign first_fail  = ff_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_hw1_sweep_ctrl.sv
// tb/tb_hw1_sweep_ctrl.sv - directed scoreboard bench for hw1_sweep_ctrl with a parity model of hw1
module tb_hw1_sweep_ctrl;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  err;
    logic        fv;
    logic [3:0]  ff;
    logic        pass;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, abort0, abort1;
  logic [15:0] exp0, exp1;
  logic        f0, f1;
  logic [3:0]  vec0, vec1, ff0, ff1;
  logic        busy0, busy1, done0, done1, fv0, fv1, pass0, pass1;
  logic [15:0] tt0, tt1;
  logic [4:0]  err0, err1;

  int sel;
  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  o_vec, o_ff;
  logic        o_busy, o_done, o_fv, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_err;

  logic [3:0] vq[$];
  res_t       rq[$];

  always #5 clk = ~clk;

  assign f0 = ^vec0;
  assign f1 = ^vec1;

  assign o_vec  = (sel == 1) ? vec1  : vec0;
  assign o_ff   = (sel == 1) ? ff1   : ff0;
  assign o_busy = (sel == 1) ? busy1 : busy0;
  assign o_done = (sel == 1) ? done1 : done0;
  assign o_fv   = (sel == 1) ? fv1   : fv0;
  assign o_pass = (sel == 1) ? pass1 : pass0;
  assign o_tt   = (sel == 1) ? tt1   : tt0;
  assign o_err  = (sel == 1) ? err1  : err0;

  hw1_sweep_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0), .f_in(f0),
    .vec(vec0), .busy(busy0), .done(done0), .truth_table(tt0), .err_cnt(err0),
    .fail_valid(fv0), .first_fail(ff0), .pass(pass0)
  );

  hw1_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1), .f_in(f1),
    .vec(vec1), .busy(busy1), .done(done1), .truth_table(tt1), .err_cnt(err1),
    .fail_valid(fv1), .first_fail(ff1), .pass(pass1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel == 1) abort1 = v; else abort0 = v;
  endtask

  task automatic set_exp(input logic [15:0] v);
    if (sel == 1) exp1 = v; else exp0 = v;
  endtask

  function automatic res_t model(input logic [15:0] e);
    res_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      r.tt[i] = ^v;
      if (r.tt[i] != e[i]) begin
        r.err = r.err + 5'd1;
        if (!r.fv) begin
          r.fv = 1'b1;
          r.ff = v;
        end
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"},  32'(o_vec),  32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_tt"},   32'(o_tt),   32'd0);
    chk({tag, "_err"},  32'(o_err),  32'd0);
    chk({tag, "_fv"},   32'(o_fv),   32'd0);
    chk({tag, "_ff"},   32'(o_ff),   32'd0);
    chk({tag, "_pass"}, 32'(o_pass), 32'd0);
  endtask

  // Full sweep; poke re-asserts start mid-sweep and during DONE to show it is ignored.
  task automatic run_sweep(input logic [15:0] e, input int settle, input bit poke);
    res_t       r;
    int         n, run, lim, extra;
    logic [3:0] prev;
    bit         seen_done;
    lim = 16 * (settle + 1) + 1;
    set_exp(e);
    rq.push_back(model(e));
    for (int i = 0; i < 16; i++) vq.push_back(4'(i));
    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_pass_clr", 32'(o_pass), 32'd0);
    chk("start_tt_clr", 32'(o_tt), 32'd0);
    chk("start_err_clr", 32'(o_err), 32'd0);
    chk("start_fv_clr", 32'(o_fv), 32'd0);
    chk("vec_step", 32'(o_vec), 32'(vq.pop_front()));
    prev = o_vec;
    run = 1;
    n = 0;
    seen_done = 1'b0;
    while (!seen_done && n < lim + 20) begin
      if (poke && (n == 3 || n == lim - 1)) set_start(1'b1);
      tick();
      n++;
      set_start(1'b0);
      if (o_done) begin
        seen_done = 1'b1;
        chk("done_edge", 32'(n), 32'(lim));
        chk("done_busy", 32'(o_busy), 32'd0);
        chk("done_vec", 32'(o_vec), 32'd0);
        chk("hold_last", 32'(run), 32'(settle + 1));
      end else if (o_busy && o_vec != prev) begin
        chk("hold", 32'(run), 32'(settle + 1));
        if (vq.size() > 0) chk("vec_step", 32'(o_vec), 32'(vq.pop_front()));
        else chk("vec_extra", 32'(o_vec), 32'hffff);
        prev = o_vec;
        run = 1;
      end else if (o_busy) begin
        run++;
      end
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    chk("vq_empty", 32'(vq.size()), 32'd0);
    vq.delete();
    r = rq.pop_front();
    chk("res_tt", 32'(o_tt), 32'(r.tt));
    chk("res_err", 32'(o_err), 32'(r.err));
    chk("res_fv", 32'(o_fv), 32'(r.fv));
    chk("res_ff", 32'(o_ff), 32'(r.ff));
    chk("res_pass", 32'(o_pass), 32'(r.pass));
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done || o_busy) extra++;
    end
    chk("single_done", 32'(extra), 32'd0);
  endtask

  initial begin
    int   dcnt;
    res_t m;
    sel    = 0;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    abort0 = 1'b0; abort1 = 1'b0;
    exp0   = 16'h0; exp1 = 16'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_sweep(16'h6996, 1, 1'b0);
    run_sweep(16'h6997, 1, 1'b0);
    run_sweep(16'h0000, 1, 1'b0);
    run_sweep(16'h0000, 1, 1'b0);

    set_exp(16'h6996);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (9) tick();
    set_abort(1'b1);
    tick();
    set_abort(1'b0);
    m = model(16'h6996);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_vec", 32'(o_vec), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_tt_hi", 32'(o_tt[15:5]), 32'd0);
    chk("abort_tt", 32'(o_tt), 32'(m.tt & 16'h000f));
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_done || o_busy) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_sweep(16'h6996, 1, 1'b0);

    set_start(1'b1);
    set_abort(1'b1);
    tick();
    set_start(1'b0);
    set_abort(1'b0);
    chk("abort_wins", 32'(o_busy), 32'd0);

    run_sweep(16'h6996, 1, 1'b1);

    set_exp(16'h0000);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (6) tick();
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    chk("pre_rst_err", 32'(o_err), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(o_busy), 32'd0);
    tick();
    chk("post_rst_idle2", 32'(o_busy), 32'd0);

    sel = 1;
    #1;
    check_all_zero("settle3_init");
    run_sweep(16'h6996, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
